// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers.
// Byte order: byte 0 is bits [127:120]; word0 = bytes 0..3 = column 0.
package aes_pkg;

   localparam int NR = 10;
   localparam int NK = 4;

   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } fsm_t;

   // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ aa;
         aa = xtime(aa);
      end
      return acc;
   endfunction

endpackage

// File: rtl/aes_add_round_key.sv
// AddRoundKey: bitwise XOR of state and round key.
module aes_add_round_key (
   input  logic [127:0] state,
   input  logic [127:0] rk,
   output logic [127:0] result
);

   assign result = state ^ rk;

endmodule

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: RotWord, SubWord, Rcon, then the XOR chain.
module aes_key_step (
   input  logic [31:0] rk0,
   input  logic [31:0] rk1,
   input  logic [31:0] rk2,
   input  logic [31:0] rk3,
   input  logic [7:0]  rcon,
   output logic [31:0] nk0,
   output logic [31:0] nk1,
   output logic [31:0] nk2,
   output logic [31:0] nk3
);

   logic [31:0] rot;
   logic [31:0] sub;

   assign rot = {rk3[23:0], rk3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox u_sbox (
         .val (rot[8*i +: 8]),
         .sub (sub[8*i +: 8])
      );
   end

   assign nk0 = rk0 ^ sub ^ {rcon, 24'h000000};
   assign nk1 = rk1 ^ nk0;
   assign nk2 = rk2 ^ nk1;
   assign nk3 = rk3 ^ nk2;

endmodule

// File: rtl/aes_mix_columns.sv
// MixColumns: each column multiplied by the circulant {02,03,01,01} in GF(2^8).
module aes_mix_columns
   import aes_pkg::*;
(
   input  logic [127:0] state,
   output logic [127:0] result
);

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign {a0, a1, a2, a3} = state[127 - 32*c -: 32];
      assign result[127 - 32*c -: 32] = {
         xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
         a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
         a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
         xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
   end

endmodule

// File: rtl/aes_sbox.sv
// AES S-box: multiplicative inverse (x^254) followed by the affine transform.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] val,
   output logic [7:0] sub
);

   logic [7:0] inv;
   logic [7:0] pw;

   // 254 = 0b11111110, so x^254 is the product of x^2, x^4, ... x^128.
   always_comb begin
      pw  = val;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         pw  = gf_mul(pw, pw);
         inv = gf_mul(inv, pw);
      end
      sub = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

// File: rtl/aes_shift_rows.sv
// ShiftRows: row r rotates left by r columns.
module aes_shift_rows (
   input  logic [127:0] state,
   output logic [127:0] result
);

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int DST = 4 * c + r;
         localparam int SRC = 4 * ((c + r) % 4) + r;
         assign result[127 - 8*DST -: 8] = state[127 - 8*SRC -: 8];
      end
   end

endmodule

// File: rtl/aes_sub_bytes.sv
// SubBytes: sixteen independent S-box lookups over the state.
module aes_sub_bytes (
   input  logic [127:0] state,
   output logic [127:0] result
);

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_sbox u_sbox (
         .val (state[8*i +: 8]),
         .sub (result[8*i +: 8])
      );
   end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption: one round per clock with on-the-fly key expansion.
module aes128_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_in,
   input  logic [31:0] pt0_in,
   input  logic [31:0] pt1_in,
   input  logic [31:0] pt2_in,
   input  logic [31:0] pt3_in,
   input  logic [31:0] key0_in,
   input  logic [31:0] key1_in,
   input  logic [31:0] key2_in,
   input  logic [31:0] key3_in,
   output logic        ready_out,
   output logic        busy_out,
   output logic        done_out,
   output logic [31:0] ct0_out,
   output logic [31:0] ct1_out,
   output logic [31:0] ct2_out,
   output logic [31:0] ct3_out
);

   if (NR != aes_pkg::NR) begin : g_nr_check
      $error("aes128_round_ctrl supports only NR = 10");
   end

   localparam logic [3:0] LAST_MID = 4'(NR - 1);

   fsm_t         fsm_q, fsm_d;
   logic         load, step;
   logic [127:0] state_q, rk_q, ct_q;
   logic [3:0]   round_q;
   logic [7:0]   rcon_q;

   logic [127:0] pt_w, key_w, init_w;
   logic [127:0] sb_w, sr_w, mc_w, ark_in_w, ark_out_w, rk_next_w;

   assign pt_w  = {pt0_in, pt1_in, pt2_in, pt3_in};
   assign key_w = {key0_in, key1_in, key2_in, key3_in};

   aes_add_round_key u_ark_init (.state(pt_w), .rk(key_w), .result(init_w));

   aes_sub_bytes   u_sb (.state(state_q), .result(sb_w));
   aes_shift_rows  u_sr (.state(sb_w),    .result(sr_w));
   aes_mix_columns u_mc (.state(sr_w),    .result(mc_w));

   aes_key_step u_ks (
      .rk0  (rk_q[127:96]),
      .rk1  (rk_q[95:64]),
      .rk2  (rk_q[63:32]),
      .rk3  (rk_q[31:0]),
      .rcon (rcon_q),
      .nk0  (rk_next_w[127:96]),
      .nk1  (rk_next_w[95:64]),
      .nk2  (rk_next_w[63:32]),
      .nk3  (rk_next_w[31:0])
   );

   // The last round skips MixColumns.
   assign ark_in_w = (fsm_q == FINAL) ? sr_w : mc_w;

   aes_add_round_key u_ark (.state(ark_in_w), .rk(rk_next_w), .result(ark_out_w));

   always_comb begin
      fsm_d     = fsm_q;
      load      = 1'b0;
      step      = 1'b0;
      ready_out = 1'b0;
      busy_out  = 1'b0;
      done_out  = 1'b0;
      case (fsm_q)
         IDLE: begin
            ready_out = 1'b1;
            if (start_in) begin
               load  = 1'b1;
               fsm_d = ROUND;
            end
         end
         ROUND: begin
            busy_out = 1'b1;
            step     = 1'b1;
            if (round_q == LAST_MID) fsm_d = FINAL;
         end
         FINAL: begin
            busy_out = 1'b1;
            step     = 1'b1;
            fsm_d    = DONE;
         end
         DONE: begin
            done_out = 1'b1;
            fsm_d    = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm_q <= IDLE;
      else     fsm_q <= fsm_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= '0;
         rk_q    <= '0;
         ct_q    <= '0;
         round_q <= '0;
         rcon_q  <= RCON_INIT;
      end else if (load) begin
         state_q <= init_w;
         rk_q    <= key_w;
         round_q <= 4'd1;
         rcon_q  <= RCON_INIT;
      end else if (step) begin
         state_q <= ark_out_w;
         rk_q    <= rk_next_w;
         round_q <= round_q + 4'd1;
         rcon_q  <= xtime(rcon_q);
         if (fsm_q == FINAL) ct_q <= ark_out_w;
      end
   end

   assign ct0_out = ct_q[127:96];
   assign ct1_out = ct_q[95:64];
   assign ct2_out = ct_q[63:32];
   assign ct3_out = ct_q[31:0];

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl using FIPS-197 vectors and an expected-ciphertext queue.
module tb_aes128_round_ctrl;

   logic        clk, rst, start_in;
   logic [31:0] pt0_in, pt1_in, pt2_in, pt3_in;
   logic [31:0] key0_in, key1_in, key2_in, key3_in;
   logic        ready_out, busy_out, done_out;
   logic [31:0] ct0_out, ct1_out, ct2_out, ct3_out;

   int n_cmp = 0;
   int n_bad = 0;
   logic [127:0] exp_q[$];

   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   logic [127:0] ct_all;
   assign ct_all = {ct0_out, ct1_out, ct2_out, ct3_out};

   aes128_round_ctrl #(.NR(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_in  (start_in),
      .pt0_in    (pt0_in),
      .pt1_in    (pt1_in),
      .pt2_in    (pt2_in),
      .pt3_in    (pt3_in),
      .key0_in   (key0_in),
      .key1_in   (key1_in),
      .key2_in   (key2_in),
      .key3_in   (key3_in),
      .ready_out (ready_out),
      .busy_out  (busy_out),
      .done_out  (done_out),
      .ct0_out   (ct0_out),
      .ct1_out   (ct1_out),
      .ct2_out   (ct2_out),
      .ct3_out   (ct3_out)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=summary");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      check(tag, {127'b0, obs}, {127'b0, exp});
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      check(tag, {96'b0, 32'(obs)}, {96'b0, 32'(exp)});
   endtask

   task automatic drive_vec(input logic [127:0] pt, input logic [127:0] key);
      {pt0_in, pt1_in, pt2_in, pt3_in}     = pt;
      {key0_in, key1_in, key2_in, key3_in} = key;
   endtask

   task automatic pop_check(input string tag);
      logic [127:0] e;
      if (exp_q.size() == 0) begin
         check_int({tag, "_queue_nonempty"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_ct"}, ct_all, e);
      end
   endtask

   // One complete encryption from IDLE, including latency and busy-width checks.
   task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] exp, input bit probe, input string tag);
      int cyc;
      int busy_n;
      bit got;
      drive_vec(pt, key);
      check1({tag, "_ready_before"}, ready_out, 1'b1);
      start_in = 1'b1;
      exp_q.push_back(exp);
      cyc = 0;
      busy_n = 0;
      got = 1'b0;
      while (!got && cyc < 30) begin
         tick();
         cyc++;
         if (cyc == 1) start_in = 1'b0;
         if (busy_out) busy_n++;
         if (probe && cyc <= 10)
            check($sformatf("%s_rcon_r%0d", tag, cyc), {120'b0, dut.rcon_q}, {120'b0, rcon_tab[cyc-1]});
         if (done_out) got = 1'b1;
      end
      check1({tag, "_done_seen"}, got, 1'b1);
      if (got) begin
         check_int({tag, "_latency"}, cyc, 11);
         check_int({tag, "_busy_cycles"}, busy_n, 10);
         pop_check(tag);
         if (probe) check({tag, "_rk10"}, dut.rk_q, RK10_B);
      end else begin
         void'(exp_q.pop_front());
      end
      tick();
      check1({tag, "_done_one_cycle"}, done_out, 1'b0);
      check1({tag, "_ready_after"}, ready_out, 1'b1);
   endtask

   initial begin
      int cyc;
      int ndone;
      int accepted;
      int last_done;
      bit got;
      bit use_c;
      bit swap;
      logic [127:0] cur_ct;

      // reset
      rst = 1'b1;
      start_in = 1'b0;
      drive_vec('0, '0);
      tick();
      tick();
      check1("rst_ready", ready_out, 1'b1);
      check1("rst_busy", busy_out, 1'b0);
      check1("rst_done", done_out, 1'b0);
      check("rst_ct", ct_all, '0);
      check("rst_rcon", {120'b0, dut.rcon_q}, {120'b0, 8'h01});
      rst = 1'b0;
      tick();

      // App. B with internal probes, then App. C.1
      run_block(PT_B, KEY_B, CT_B, 1'b1, "app_b");
      run_block(PT_C, KEY_C, CT_C, 1'b0, "app_c1");

      // start pulses while busy and in DONE, inputs scrambled after E0
      drive_vec(PT_B, KEY_B);
      start_in = 1'b1;
      exp_q.push_back(CT_B);
      tick();
      cyc = 1;
      got = 1'b0;
      while (!got && cyc < 30) begin
         start_in = 1'($urandom_range(0, 1));
         drive_vec({$urandom(), $urandom(), $urandom(), $urandom()},
                   {$urandom(), $urandom(), $urandom(), $urandom()});
         tick();
         cyc++;
         if (done_out) got = 1'b1;
      end
      check1("ign_done_seen", got, 1'b1);
      check_int("ign_latency", cyc, 11);
      pop_check("ign");
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      check1("ign_ready_after_done", ready_out, 1'b1);
      ndone = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done_out) ndone++;
         if (busy_out) ndone++;
      end
      check_int("ign_no_extra_activity", ndone, 0);
      check("ign_ct_held", ct_all, CT_B);

      // start held high: B, C.1, B back to back
      use_c = 1'b0;
      drive_vec(PT_B, KEY_B);
      start_in = 1'b1;
      accepted = 0;
      ndone = 0;
      last_done = 0;
      cur_ct = CT_B;
      for (int i = 1; i <= 60 && ndone < 3; i++) begin
         swap = 1'b0;
         if (ready_out && accepted < 3) begin
            exp_q.push_back(use_c ? CT_C : CT_B);
            accepted++;
            swap = 1'b1;
         end
         tick();
         if (swap) begin
            use_c = ~use_c;
            drive_vec(use_c ? PT_C : PT_B, use_c ? KEY_C : KEY_B);
            if (accepted == 3) start_in = 1'b0;
         end
         if (done_out) begin
            if (ndone > 0) check_int($sformatf("b2b_spacing%0d", ndone), i - last_done, 12);
            last_done = i;
            ndone++;
            cur_ct = (ndone == 2) ? CT_C : CT_B;
            pop_check($sformatf("b2b_blk%0d", ndone));
         end else begin
            check($sformatf("b2b_ct_stable_c%0d", i), ct_all, cur_ct);
         end
      end
      check_int("b2b_done_count", ndone, 3);
      tick();

      // asynchronous reset during round 5
      drive_vec(PT_B, KEY_B);
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check1("mid_busy_before_rst", busy_out, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check1("mid_rst_ready", ready_out, 1'b1);
      check1("mid_rst_busy", busy_out, 1'b0);
      check1("mid_rst_done", done_out, 1'b0);
      check("mid_rst_ct", ct_all, '0);
      check("mid_rst_state", dut.state_q, '0);
      check("mid_rst_rk", dut.rk_q, '0);
      tick();
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done_out) ndone++;
      end
      check_int("mid_rst_no_done", ndone, 0);
      run_block(PT_B, KEY_B, CT_B, 1'b0, "post_rst");

      check_int("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
